// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: command codes, FSM states and
// small state-classification helpers.
package program_loader_pkg;

  localparam logic [7:0] CMD_LOAD_IM = 8'h01;
  localparam logic [7:0] CMD_LOAD_DM = 8'h02;
  localparam logic [7:0] CMD_RUN     = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_PAYLOAD,
    ST_CKSUM,
    ST_RUN,
    ST_ERROR
  } state_e;

  function automatic logic is_busy(state_e s);
    return !(s inside {ST_IDLE, ST_RUN, ST_ERROR});
  endfunction

  function automatic logic accepts_bytes(state_e s);
    return !(s inside {ST_RUN, ST_ERROR});
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Host byte link plus IM/DM write ports and core control of the program loader.
// master = host/memory side, slave = loader.
interface program_loader_if #(
  parameter int IM_AW = 10,
  parameter int DM_AW = 10
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             im_we;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_wdata;
  logic             dm_we;
  logic [DM_AW-1:0] dm_addr;
  logic [7:0]       dm_wdata;
  logic             cpu_run;
  logic             busy;
  logic             error;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, im_we, im_addr, im_wdata, dm_we, dm_addr, dm_wdata,
           cpu_run, busy, error
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, im_we, im_addr, im_wdata, dm_we, dm_addr, dm_wdata,
           cpu_run, busy, error
  );
endinterface

// File: rtl/program_loader_word_pack.sv
// Byte -> 32-bit big-endian word assembler. word_done flags the byte that
// completes a word; word is then {first three bytes, current byte}.
module loader_word_pack (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_done,
  output logic [31:0] word
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] shift_q, shift_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would infer a latch.
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clear) begin
      idx_d   = '0;
      shift_d = '0;
    end else if (byte_valid) begin
      idx_d   = idx_q + 2'd1;
      shift_d = {shift_q[15:0], byte_in};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  assign word_done = byte_valid & ~clear & (idx_q == 2'd3);
  assign word      = {shift_q, byte_in};

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: writes IM words / DM bytes and releases the core
// on RUN. Define LOADER_CHECKSUM_EN to require an XOR checksum byte per LOAD frame.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int IM_AW = 10,
  parameter int DM_AW = 10
) (
  input logic             clk,
  input logic             reset,
  program_loader_if.slave bus
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_e FRAME_END = ST_CKSUM;
`else
  localparam state_e FRAME_END = ST_IDLE;
`endif

  state_e           state_q, state_d;
  logic             load_im_q, load_im_d;
  logic [15:0]      count_q, count_d;
  logic [IM_AW:0]   im_ptr_q, im_ptr_d;
  logic [DM_AW:0]   dm_ptr_q, dm_ptr_d;
  logic             im_we_q, im_we_d;
  logic [IM_AW-1:0] im_addr_q, im_addr_d;
  logic [31:0]      im_wdata_q, im_wdata_d;
  logic             dm_we_q, dm_we_d;
  logic [DM_AW-1:0] dm_addr_q, dm_addr_d;
  logic [7:0]       dm_wdata_q, dm_wdata_d;
  logic             rx_ready_q, rx_ready_d;
  logic             cpu_run_q, cpu_run_d;
  logic             busy_q, busy_d;
  logic             error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       cksum_q, cksum_d;
`endif

  logic        accept;
  logic        pack_done;
  logic [31:0] pack_word;

  assign accept = bus.rx_valid & rx_ready_q;

  loader_word_pack u_word_pack (
    .clk        (clk),
    .reset      (reset),
    .clear      (state_q != ST_PAYLOAD),
    .byte_valid (accept & (state_q == ST_PAYLOAD) & load_im_q),
    .byte_in    (bus.rx_data),
    .word_done  (pack_done),
    .word       (pack_word)
  );

  always_comb begin
    state_d    = state_q;
    load_im_d  = load_im_q;
    count_d    = count_q;
    im_ptr_d   = im_ptr_q;
    dm_ptr_d   = dm_ptr_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    dm_we_d    = 1'b0;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    cksum_d    = cksum_q;
`endif

    if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
`ifdef LOADER_CHECKSUM_EN
          cksum_d = '0;
`endif
          case (bus.rx_data)
            CMD_LOAD_IM: begin
              state_d   = ST_CNT_HI;
              load_im_d = 1'b1;
              im_ptr_d  = '0;
            end
            CMD_LOAD_DM: begin
              state_d   = ST_CNT_HI;
              load_im_d = 1'b0;
              dm_ptr_d  = '0;
            end
            CMD_RUN: state_d = ST_RUN;
            default: state_d = ST_ERROR;
          endcase
        end
        ST_CNT_HI: begin
          count_d = {bus.rx_data, 8'h00};
          state_d = ST_CNT_LO;
        end
        ST_CNT_LO: begin
          count_d = {count_q[15:8], bus.rx_data};
          state_d = (count_d == 16'd0) ? FRAME_END : ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
`ifdef LOADER_CHECKSUM_EN
          cksum_d = cksum_q ^ bus.rx_data;
`endif
          // The pointer's extra top bit marks "memory full"; a unit arriving
          // then is dropped and the loader stops rather than wrapping.
          if (load_im_q) begin
            if (pack_done) begin
              if (im_ptr_q[IM_AW]) begin
                state_d = ST_ERROR;
              end else begin
                im_we_d    = 1'b1;
                im_addr_d  = im_ptr_q[IM_AW-1:0];
                im_wdata_d = pack_word;
                im_ptr_d   = im_ptr_q + (IM_AW+1)'(4);
                count_d    = count_q - 16'd1;
                if (count_q == 16'd1) state_d = FRAME_END;
              end
            end
          end else begin
            if (dm_ptr_q[DM_AW]) begin
              state_d = ST_ERROR;
            end else begin
              dm_we_d    = 1'b1;
              dm_addr_d  = dm_ptr_q[DM_AW-1:0];
              dm_wdata_d = bus.rx_data;
              dm_ptr_d   = dm_ptr_q + (DM_AW+1)'(1);
              count_d    = count_q - 16'd1;
              if (count_q == 16'd1) state_d = FRAME_END;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CKSUM: state_d = (bus.rx_data == cksum_q) ? ST_IDLE : ST_ERROR;
`endif
        default: state_d = state_q;
      endcase
    end

    rx_ready_d = accepts_bytes(state_d);
    busy_d     = is_busy(state_d);
    cpu_run_d  = (state_d == ST_RUN);
    error_d    = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      load_im_q  <= 1'b0;
      count_q    <= '0;
      im_ptr_q   <= '0;
      dm_ptr_q   <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      rx_ready_q <= 1'b1;
      cpu_run_q  <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      cksum_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      load_im_q  <= load_im_d;
      count_q    <= count_d;
      im_ptr_q   <= im_ptr_d;
      dm_ptr_q   <= dm_ptr_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      rx_ready_q <= rx_ready_d;
      cpu_run_q  <= cpu_run_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
      cksum_q    <= cksum_d;
`endif
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.im_we    = im_we_q;
  assign bus.im_addr  = im_addr_q;
  assign bus.im_wdata = im_wdata_q;
  assign bus.dm_we    = dm_we_q;
  assign bus.dm_addr  = dm_addr_q;
  assign bus.dm_wdata = dm_wdata_q;
  assign bus.cpu_run  = cpu_run_q;
  assign bus.busy     = busy_q;
  assign bus.error    = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: IM/DM frames, RUN, errors,
// capacity limit, stalls, mid-frame reset and (when enabled) checksums.
module tb_program_loader;

  localparam int IM_AW = 10;
  localparam int DM_AW = 10;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  logic [IM_AW+31:0] im_log[$];
  logic [DM_AW+7:0]  dm_log[$];

  program_loader_if #(.IM_AW(IM_AW), .DM_AW(DM_AW)) bus ();

  program_loader #(.IM_AW(IM_AW), .DM_AW(DM_AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write logger, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.im_we) im_log.push_back({bus.im_addr, bus.im_wdata});
    if (bus.dm_we) dm_log.push_back({bus.dm_addr, bus.dm_wdata});
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    im_log.delete();
    dm_log.delete();
  endtask

  initial begin
    int bad;
    vectors      = 0;
    miscompares  = 0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    reset        = 1'b1;
    idle(2);

    // Reset state
    check("rst_rx_ready", 64'(bus.rx_ready), 64'd1);
    check("rst_outputs",
          64'({bus.im_we, bus.dm_we, bus.cpu_run, bus.busy, bus.error}), 64'd0);
    check("rst_addrs", 64'({bus.im_addr, bus.dm_addr}), 64'd0);
    reset = 1'b0;
    idle(1);
    check("post_rst_idle", 64'({bus.rx_ready, bus.busy, bus.error}), 64'b100);

    // LOAD_IM, two words
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
    check("im_busy", 64'(bus.busy), 64'd1);
    send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h20); send_byte(8'h09); send_byte(8'h00); send_byte(8'h0A);
    idle(2);
    check("im_count", 64'(im_log.size()), 64'd2);
    if (im_log.size() == 2) begin
      check("im_w0", 64'(im_log[0]), {22'd0, 10'd0, 32'h20080005});
      check("im_w1", 64'(im_log[1]), {22'd0, 10'd4, 32'h2009000A});
    end
    check("im_no_dm", 64'(dm_log.size()), 64'd0);
    check("im_back_idle", 64'({bus.busy, bus.error, bus.rx_ready}), 64'b001);

    // Stall mid-word; address restarts at 0
    im_log.delete();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22);
    idle(5);
    check("stall_no_write", 64'(im_log.size()), 64'd0);
    check("stall_busy", 64'(bus.busy), 64'd1);
    send_byte(8'h33); send_byte(8'h44);
    idle(2);
    check("stall_count", 64'(im_log.size()), 64'd1);
    if (im_log.size() == 1)
      check("stall_word", 64'(im_log[0]), {22'd0, 10'd0, 32'h11223344});

    // Reset mid-word discards the partial frame
    im_log.delete();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h55); send_byte(8'h66);
    reset = 1'b1;
    #1;
    check("midrst_state", 64'({bus.busy, bus.rx_ready, bus.im_we}), 64'b010);
    idle(2);
    reset = 1'b0;
    idle(2);
    check("midrst_no_write", 64'(im_log.size()), 64'd0);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    idle(2);
    check("midrst_fresh_count", 64'(im_log.size()), 64'd1);
    if (im_log.size() == 1)
      check("midrst_fresh_word", 64'(im_log[0]), {22'd0, 10'd0, 32'hDEADBEEF});

    // LOAD_DM three bytes, then RUN
    im_log.delete();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    idle(2);
    check("dm_count", 64'(dm_log.size()), 64'd3);
    if (dm_log.size() == 3) begin
      check("dm_b0", 64'(dm_log[0]), {46'd0, 10'd0, 8'hAA});
      check("dm_b1", 64'(dm_log[1]), {46'd0, 10'd1, 8'hBB});
      check("dm_b2", 64'(dm_log[2]), {46'd0, 10'd2, 8'hCC});
    end
    check("dm_no_im", 64'(im_log.size()), 64'd0);
    check("pre_run", 64'(bus.cpu_run), 64'd0);
    send_byte(8'h03);
    check("run_state", 64'({bus.cpu_run, bus.rx_ready, bus.busy, bus.error}), 64'b1000);
    bus.rx_data  = 8'h01;
    bus.rx_valid = 1'b1;
    idle(3);
    bus.rx_valid = 1'b0;
    check("run_terminal", 64'({bus.cpu_run, bus.busy, bus.error}), 64'b100);

    // Unknown command -> terminal ERROR
    do_reset();
    send_byte(8'h7F);
    check("err_state", 64'({bus.error, bus.cpu_run, bus.rx_ready}), 64'b100);
    bus.rx_data  = 8'h03;
    bus.rx_valid = 1'b1;
    idle(3);
    bus.rx_valid = 1'b0;
    check("err_ignores_run", 64'({bus.error, bus.cpu_run}), 64'b10);

    // DM capacity: COUNT = 1025 -> 1024 writes then ERROR
    do_reset();
    send_byte(8'h02); send_byte(8'h04); send_byte(8'h01);
    for (int i = 0; i < 1024; i++) send_byte(8'(i));
    idle(1);
    check("cap_full_no_err", 64'({bus.error, bus.busy}), 64'b01);
    send_byte(8'h99);
    idle(2);
    check("cap_err", 64'({bus.error, bus.rx_ready}), 64'b10);
    check("cap_writes", 64'(dm_log.size()), 64'd1024);
    bad = 0;
    for (int i = 0; i < dm_log.size(); i++)
      if (dm_log[i] !== {10'(i), 8'(i)}) bad++;
    check("cap_data", 64'(bad), 64'd0);

    do_reset();
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h26);
    idle(2);
    check("ck_good", 64'({bus.error, bus.busy}), 64'b00);
    check("ck_good_writes", 64'(dm_log.size()), 64'd2);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    check("ck_zero_wait", 64'(bus.busy), 64'd1);
    send_byte(8'h00);
    check("ck_zero_ok", 64'({bus.error, bus.busy}), 64'b00);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h27);
    idle(2);
    check("ck_bad", 64'({bus.error, bus.cpu_run}), 64'b10);
    check("ck_bad_kept", 64'(dm_log.size()), 64'd4);
`else
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h5A);
    check("nock_idle", 64'({bus.busy, bus.error}), 64'b00);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    check("nock_zero_idle", 64'({bus.busy, bus.error}), 64'b00);
    send_byte(8'h03);
    idle(1);
    check("nock_run", 64'({bus.cpu_run, bus.error}), 64'b10);
    check("nock_writes", 64'(dm_log.size()), 64'd1);
    if (dm_log.size() == 1)
      check("nock_byte", 64'(dm_log[0]), {46'd0, 10'd0, 8'h5A});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
